// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS multicycle control unit.
// MIPS_CTRL_JUMP_EN adds the j instruction to the supported opcode set.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [1:0] ALUB_REG     = 2'b00;
   localparam logic [1:0] ALUB_FOUR    = 2'b01;
   localparam logic [1:0] ALUB_IMM     = 2'b10;
   localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       branch;
      logic       ir_write;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_src;
      logic       instr_done;
      logic       illegal_op;
   } ctrl_t;

   function automatic logic op_supported(input logic [5:0] op);
      logic ok;
      case (op)
         OP_RTYPE, OP_BEQ, OP_ADDI, OP_LW, OP_SW: ok = 1'b1;
`ifdef MIPS_CTRL_JUMP_EN
         OP_J:                                    ok = 1'b1;
`endif
         default:                                 ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Pure state-to-output decode for the multicycle control FSM (no input qualification).
// JUMP state decode exists only when MIPS_CTRL_JUMP_EN is defined.
module mips_ctrl_decode
   import mips_ctrl_pkg::*;
#(
   parameter int STATE_W = 4
) (
   input  logic [STATE_W-1:0] state_i,
   output ctrl_t              ctrl_o
);

   always_comb begin
      ctrl_o = '0;
      case (state_i)
         STATE_W'(S_FETCH): begin
            ctrl_o.mem_read  = 1'b1;
            ctrl_o.pc_write  = 1'b1;
            ctrl_o.ir_write  = 1'b1;
            ctrl_o.alu_src_b = ALUB_FOUR;
         end
         STATE_W'(S_DECODE): begin
            ctrl_o.alu_src_b = ALUB_IMM_SH2;
         end
         STATE_W'(S_MEMADR): begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = ALUB_IMM;
         end
         STATE_W'(S_MEMRD): begin
            ctrl_o.mem_read = 1'b1;
            ctrl_o.i_or_d   = 1'b1;
         end
         STATE_W'(S_MEMWB): begin
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.mem_to_reg = 1'b1;
            ctrl_o.instr_done = 1'b1;
         end
         STATE_W'(S_MEMWR): begin
            ctrl_o.mem_write  = 1'b1;
            ctrl_o.i_or_d     = 1'b1;
            ctrl_o.instr_done = 1'b1;
         end
         STATE_W'(S_EXEC): begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = ALUB_REG;
            ctrl_o.alu_op    = ALUOP_FUNCT;
         end
         STATE_W'(S_ALUWB): begin
            ctrl_o.reg_dst    = 1'b1;
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.instr_done = 1'b1;
         end
         STATE_W'(S_BRANCH): begin
            ctrl_o.alu_src_a  = 1'b1;
            ctrl_o.alu_src_b  = ALUB_REG;
            ctrl_o.alu_op     = ALUOP_SUB;
            ctrl_o.pc_src     = PCSRC_ALUOUT;
            ctrl_o.branch     = 1'b1;
            ctrl_o.instr_done = 1'b1;
         end
         STATE_W'(S_ADDIEX): begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = ALUB_IMM;
         end
         STATE_W'(S_ADDIWB): begin
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.instr_done = 1'b1;
         end
`ifdef MIPS_CTRL_JUMP_EN
         STATE_W'(S_JUMP): begin
            ctrl_o.pc_src     = PCSRC_JUMP;
            ctrl_o.pc_write   = 1'b1;
            ctrl_o.instr_done = 1'b1;
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore multicycle control FSM: state register, next-state logic and mem_ready qualification.
// Build option MIPS_CTRL_JUMP_EN enables the j instruction (opcode 0x02).
module mips_multicycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int STATE_W = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       branch,
   output logic       ir_write,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       mem_to_reg,
   output logic       reg_dst,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_src,
   output logic       instr_done,
   output logic       illegal_op
);

   logic [STATE_W-1:0] state_q, state_d;
   ctrl_t              raw, ctrl;
   logic               illegal;

   always_ff @(posedge clock) begin
      if (reset) state_q <= STATE_W'(S_FETCH);
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = STATE_W'(S_FETCH);
      case (state_q)
         STATE_W'(S_FETCH):  state_d = mem_ready ? STATE_W'(S_DECODE) : STATE_W'(S_FETCH);
         STATE_W'(S_DECODE): begin
            case (opcode)
               OP_LW, OP_SW: state_d = STATE_W'(S_MEMADR);
               OP_RTYPE:     state_d = STATE_W'(S_EXEC);
               OP_BEQ:       state_d = STATE_W'(S_BRANCH);
               OP_ADDI:      state_d = STATE_W'(S_ADDIEX);
`ifdef MIPS_CTRL_JUMP_EN
               OP_J:         state_d = STATE_W'(S_JUMP);
`endif
               default:      state_d = STATE_W'(S_FETCH);
            endcase
         end
         STATE_W'(S_MEMADR): state_d = (opcode == OP_SW) ? STATE_W'(S_MEMWR) : STATE_W'(S_MEMRD);
         STATE_W'(S_MEMRD):  state_d = mem_ready ? STATE_W'(S_MEMWB) : STATE_W'(S_MEMRD);
         STATE_W'(S_MEMWR):  state_d = mem_ready ? STATE_W'(S_FETCH) : STATE_W'(S_MEMWR);
         STATE_W'(S_EXEC):   state_d = STATE_W'(S_ALUWB);
         STATE_W'(S_ADDIEX): state_d = STATE_W'(S_ADDIWB);
         default:            state_d = STATE_W'(S_FETCH);
      endcase
   end

   mips_ctrl_decode #(
      .STATE_W (STATE_W)
   ) u_decode (
      .state_i (state_q),
      .ctrl_o  (raw)
   );

   assign illegal = (state_q == STATE_W'(S_DECODE)) && !op_supported(opcode);

   // Memory-completion qualification; reset forces every output low, even mid-instruction.
   always_comb begin
      ctrl = raw;
      if (state_q == STATE_W'(S_FETCH)) begin
         ctrl.pc_write = raw.pc_write & mem_ready;
         ctrl.ir_write = raw.ir_write & mem_ready;
      end
      if (state_q == STATE_W'(S_MEMWR)) ctrl.instr_done = raw.instr_done & mem_ready;
      if (illegal) begin
         ctrl.illegal_op = 1'b1;
         ctrl.instr_done = 1'b1;
      end
      if (reset) ctrl = '0;
   end

   assign pc_write   = ctrl.pc_write;
   assign branch     = ctrl.branch;
   assign ir_write   = ctrl.ir_write;
   assign i_or_d     = ctrl.i_or_d;
   assign mem_read   = ctrl.mem_read;
   assign mem_write  = ctrl.mem_write;
   assign mem_to_reg = ctrl.mem_to_reg;
   assign reg_dst    = ctrl.reg_dst;
   assign reg_write  = ctrl.reg_write;
   assign alu_src_a  = ctrl.alu_src_a;
   assign alu_src_b  = ctrl.alu_src_b;
   assign alu_op     = ctrl.alu_op;
   assign pc_src     = ctrl.pc_src;
   assign instr_done = ctrl.instr_done;
   assign illegal_op = ctrl.illegal_op;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Table-driven bench for mips_multicycle_ctrl with an expected-output queue and a variable-wait lw sequence.
module tb_mips_multicycle_ctrl;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] opcode = 6'h00;
   logic       mem_ready = 1'b1;
   logic       pc_write, branch, ir_write, i_or_d, mem_read, mem_write;
   logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
   logic [1:0] alu_src_b, alu_op, pc_src;

   typedef struct packed {
      logic       pc_write;
      logic       branch;
      logic       ir_write;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_src;
      logic       instr_done;
      logic       illegal_op;
   } outs_t;

   typedef struct {
      logic       rst;
      logic [5:0] op;
      logic       mr;
      outs_t      exp;
      string      name;
   } vec_t;

   vec_t  vecs[$];
   outs_t exp_q[$];
   string name_q[$];
   outs_t act;
   int    n_pass  = 0;
   int    n_total = 0;

   mips_multicycle_ctrl dut (
      .clock      (clock),
      .reset      (reset),
      .opcode     (opcode),
      .mem_ready  (mem_ready),
      .pc_write   (pc_write),
      .branch     (branch),
      .ir_write   (ir_write),
      .i_or_d     (i_or_d),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_to_reg (mem_to_reg),
      .reg_dst    (reg_dst),
      .reg_write  (reg_write),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_op     (alu_op),
      .pc_src     (pc_src),
      .instr_done (instr_done),
      .illegal_op (illegal_op)
   );

   always #5 clock = ~clock;

   assign act = {pc_write, branch, ir_write, i_or_d, mem_read, mem_write, mem_to_reg,
                 reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_src, instr_done, illegal_op};

   function automatic outs_t e_zero();
      outs_t o; o = '0; return o;
   endfunction
   function automatic outs_t e_fetch(input logic mr);
      outs_t o; o = '0;
      o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.pc_write = mr; o.ir_write = mr;
      return o;
   endfunction
   function automatic outs_t e_decode();
      outs_t o; o = '0; o.alu_src_b = 2'b11; return o;
   endfunction
   function automatic outs_t e_illegal();
      outs_t o; o = '0; o.alu_src_b = 2'b11; o.instr_done = 1'b1; o.illegal_op = 1'b1; return o;
   endfunction
   function automatic outs_t e_memadr();
      outs_t o; o = '0; o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; return o;
   endfunction
   function automatic outs_t e_memrd();
      outs_t o; o = '0; o.mem_read = 1'b1; o.i_or_d = 1'b1; return o;
   endfunction
   function automatic outs_t e_memwb();
      outs_t o; o = '0; o.reg_write = 1'b1; o.mem_to_reg = 1'b1; o.instr_done = 1'b1; return o;
   endfunction
   function automatic outs_t e_memwr(input logic mr);
      outs_t o; o = '0; o.mem_write = 1'b1; o.i_or_d = 1'b1; o.instr_done = mr; return o;
   endfunction
   function automatic outs_t e_exec();
      outs_t o; o = '0; o.alu_src_a = 1'b1; o.alu_op = 2'b10; return o;
   endfunction
   function automatic outs_t e_aluwb();
      outs_t o; o = '0; o.reg_dst = 1'b1; o.reg_write = 1'b1; o.instr_done = 1'b1; return o;
   endfunction
   function automatic outs_t e_branch();
      outs_t o; o = '0;
      o.alu_src_a = 1'b1; o.alu_op = 2'b01; o.pc_src = 2'b01; o.branch = 1'b1; o.instr_done = 1'b1;
      return o;
   endfunction
   function automatic outs_t e_addiwb();
      outs_t o; o = '0; o.reg_write = 1'b1; o.instr_done = 1'b1; return o;
   endfunction
   function automatic outs_t e_jump();
      outs_t o; o = '0; o.pc_src = 2'b10; o.pc_write = 1'b1; o.instr_done = 1'b1; return o;
   endfunction

   function automatic void add(input logic r, input logic [5:0] op, input logic mr,
                               input outs_t e, input string n);
      vec_t v;
      v.rst = r; v.op = op; v.mr = mr; v.exp = e; v.name = n;
      vecs.push_back(v);
   endfunction

   task automatic check(input string n, input outs_t got, input outs_t exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %05h expected %05h", n, got, exp);
   endtask

   task automatic check_bit(input string n, input logic got, input logic exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b", n, got, exp);
   endtask

   task automatic step(input logic r, input logic [5:0] op, input logic mr);
      @(posedge clock); #1;
      reset = r; opcode = op; mem_ready = mr;
   endtask

   initial begin
      int nwait, cyc, dones;
      logic done_seen;

      add(1, 6'h00, 1, e_zero(),    "rst0");
      add(1, 6'h00, 1, e_zero(),    "rst1");
      add(1, 6'h00, 1, e_zero(),    "rst2");
      add(0, 6'h00, 1, e_fetch(1),  "r_fetch");
      add(0, 6'h00, 1, e_decode(),  "r_decode");
      add(0, 6'h00, 1, e_exec(),    "r_exec");
      add(0, 6'h00, 1, e_aluwb(),   "r_aluwb");
      add(0, 6'h23, 1, e_fetch(1),  "lw_fetch");
      add(0, 6'h23, 1, e_decode(),  "lw_decode");
      add(0, 6'h23, 1, e_memadr(),  "lw_memadr");
      add(0, 6'h23, 0, e_memrd(),   "lw_memrd_w0");
      add(0, 6'h23, 0, e_memrd(),   "lw_memrd_w1");
      add(0, 6'h23, 1, e_memrd(),   "lw_memrd_rdy");
      add(0, 6'h23, 1, e_memwb(),   "lw_memwb");
      add(0, 6'h2B, 1, e_fetch(1),  "sw_fetch");
      add(0, 6'h2B, 1, e_decode(),  "sw_decode");
      add(0, 6'h2B, 1, e_memadr(),  "sw_memadr");
      add(0, 6'h2B, 1, e_memwr(1),  "sw_memwr");
      add(0, 6'h04, 1, e_fetch(1),  "beq_fetch");
      add(0, 6'h04, 1, e_decode(),  "beq_decode");
      add(0, 6'h04, 1, e_branch(),  "beq_branch");
      add(0, 6'h08, 1, e_fetch(1),  "addi_fetch");
      add(0, 6'h08, 1, e_decode(),  "addi_decode");
      add(0, 6'h08, 1, e_memadr(),  "addi_ex");
      add(0, 6'h08, 1, e_addiwb(),  "addi_wb");
      add(0, 6'h3F, 1, e_fetch(1),  "ill_fetch");
      add(0, 6'h3F, 1, e_illegal(), "ill_decode");
      add(0, 6'h02, 1, e_fetch(1),  "j_fetch");
`ifdef MIPS_CTRL_JUMP_EN
      add(0, 6'h02, 1, e_decode(),  "j_decode");
      add(0, 6'h02, 1, e_jump(),    "j_jump");
`else
      add(0, 6'h02, 1, e_illegal(), "j_illegal");
`endif
      add(0, 6'h04, 0, e_fetch(0),  "fw_fetch_wait");
      add(0, 6'h04, 1, e_fetch(1),  "fw_fetch_rdy");
      add(0, 6'h04, 1, e_decode(),  "fw_decode");
      add(0, 6'h04, 1, e_branch(),  "fw_branch");
      add(0, 6'h2B, 1, e_fetch(1),  "swr_fetch");
      add(0, 6'h2B, 1, e_decode(),  "swr_decode");
      add(0, 6'h2B, 1, e_memadr(),  "swr_memadr");
      add(0, 6'h2B, 0, e_memwr(0),  "swr_memwr_wait");
      add(1, 6'h2B, 0, e_zero(),    "swr_reset");
      add(0, 6'h00, 1, e_fetch(1),  "swr_refetch");
      add(0, 6'h00, 1, e_decode(),  "swr_decode2");
      add(0, 6'h00, 1, e_exec(),    "swr_exec");
      add(0, 6'h00, 1, e_aluwb(),   "swr_aluwb");

      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].op, vecs[i].mr);
         exp_q.push_back(vecs[i].exp);
         name_q.push_back(vecs[i].name);
         @(negedge clock);
         check(name_q.pop_front(), act, exp_q.pop_front());
      end

      // lw with a random MEMRD stall: strobes hold, one done pulse, 5+N cycles.
      nwait     = $urandom_range(1, 6);
      cyc       = 0;
      dones     = 0;
      done_seen = 1'b0;
      for (int k = 0; k < 40 && !done_seen; k++) begin
         step(0, 6'h23, !(k >= 3 && k < 3 + nwait));
         cyc++;
         @(negedge clock);
         if (k >= 3 && k < 3 + nwait) begin
            check_bit("lwv_mem_read_hold", mem_read, 1'b1);
            check_bit("lwv_i_or_d_hold", i_or_d, 1'b1);
         end
         if (instr_done) begin
            dones++;
            done_seen = 1'b1;
            check_bit("lwv_mem_to_reg", mem_to_reg, 1'b1);
         end
      end
      check_bit("lwv_done_seen", done_seen, 1'b1);
      n_total++;
      if (cyc == 5 + nwait) n_pass++;
      else $display("FAIL lwv_cycles: got %0d expected %0d", cyc, 5 + nwait);
      n_total++;
      if (dones == 1) n_pass++;
      else $display("FAIL lwv_done_count: got %0d expected 1", dones);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multicycle control unit for the MIPS core: a Moore FSM that sequences one shared ALU, one unified instruction/data memory and the register file across 3–5 cycles per instruction. It sits beside the datapath inside `mips_core`, takes the IR opcode plus a memory-ready handshake, and drives every enable and mux select. It also reports instruction completion and illegal opcodes, so the testbench and a future cycle counter can track retirement.

## Interface
Parameters:
- `STATE_W`, default 4: state register width; must cover all encoded states.

Ports:
- `clock`  in  1  single rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `opcode`  in  6  IR[31:26]; stable from DECODE until the instruction ends.
- `mem_ready`  in  1  memory has completed the current read/write this cycle.
- `pc_write`  out  1  unconditional PC load.
- `branch`  out  1  PC load qualified by ALU zero (datapath ANDs).
- `ir_write`  out  1  IR load.
- `i_or_d`  out  1  memory address mux: 0 = PC, 1 = ALUOut.
- `mem_read`, `mem_write`  out  1 each  memory strobes.
- `mem_to_reg`  out  1  write-back mux: 1 = MDR, 0 = ALUOut.
- `reg_dst`  out  1  destination: 1 = rd, 0 = rt.
- `reg_write`  out  1  register file write enable.
- `alu_src_a`  out  1  0 = PC, 1 = A.
- `alu_src_b`  out  2  00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- `alu_op`  out  2  00 = add, 01 = sub, 10 = funct-decoded.
- `pc_src`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- `instr_done`  out  1  one-cycle pulse in the final state of each instruction.
- `illegal_op`  out  1  one-cycle pulse in DECODE for an unsupported opcode.

## Operation
- Moore outputs are decoded from the state register only. Exception: `pc_write`/`ir_write` in FETCH are also qualified by `mem_ready`.
- Any output not listed for a state is 0. Multi-bit selects default to 00.
- State behaviour:
  - FETCH: `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_src`=00; `ir_write`=`pc_write`=`mem_ready`. Holds while `mem_ready`=0, then goes to DECODE.
  - DECODE: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00. Dispatch on opcode: 0x23/0x2B → MEMADR; 0x00 → EXEC; 0x04 → BRANCH; 0x08 → ADDIEX; 0x02 → JUMP. Any other opcode → FETCH, with `illegal_op`=1 and `instr_done`=1.
  - MEMADR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Goes to MEMRD for 0x23, MEMWR for 0x2B.
  - MEMRD: `mem_read`=1, `i_or_d`=1. Holds until `mem_ready`, then goes to MEMWB.
  - MEMWB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0, `instr_done`=1, then FETCH.
  - MEMWR: `mem_write`=1, `i_or_d`=1. Holds until `mem_ready`; `instr_done`=`mem_ready`; then FETCH.
  - EXEC: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10, then ALUWB.
  - ALUWB: `reg_dst`=1, `reg_write`=1, `mem_to_reg`=0, `instr_done`=1, then FETCH.
  - BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_src`=01, `branch`=1, `instr_done`=1, then FETCH.
  - ADDIEX: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00, then ADDIWB.
  - ADDIWB: `reg_dst`=0, `reg_write`=1, `instr_done`=1, then FETCH.
  - JUMP: `pc_src`=10, `pc_write`=1, `instr_done`=1, then FETCH.
- Unreachable state encodings go to FETCH on the next edge with all outputs 0.

## Timing
- Reset: while `reset`=1, the state loads FETCH at every edge and all outputs are forced to 0 (including strobes and pulses). The first FETCH cycle with live outputs is the first cycle after `reset` falls.
- Reset mid-instruction: the instruction is abandoned, with no partial `reg_write`/`mem_write` in the reset cycle, and the FSM resumes at FETCH.
- Cycles per instruction with `mem_ready` tied to 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Each cycle of `mem_ready`=0 in FETCH/MEMRD/MEMWR adds exactly one cycle. Strobes and the address mux are held constant throughout the wait.
- `instr_done` is high in exactly one cycle per instruction, never in FETCH. `illegal_op` implies `instr_done` in the same cycle.

## Configuration
- `MIPS_CTRL_JUMP_EN`:
  - Defined: opcode 0x02 dispatches to JUMP.
  - Undefined: the JUMP state is not compiled, 0x02 is treated as illegal (`illegal_op` pulse), and `pc_src` never takes 10.

## Structure
- Shared package `mips_ctrl_pkg` holds:
  - state encodings;
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J);
  - `alu_src_b`, `alu_op` and `pc_src` encodings.
- Sub-module `mips_ctrl_decode`: combinational state-to-output decoder. The top level keeps the state register, next-state logic and `mem_ready` qualification.

## Test plan
- Reset held 3 cycles, then released with `mem_ready`=1 and opcode 0x00 → all outputs 0 during reset; FETCH→DECODE→EXEC→ALUWB; `reg_write`=1 and `reg_dst`=1 in cycle 4; `instr_done` pulse once.
- lw (0x23) with `mem_ready` low for 2 cycles in MEMRD → 7 cycles total; `mem_read`=1 and `i_or_d`=1 constant over the wait; `mem_to_reg`=1 in MEMWB.
- sw (0x2B) → `mem_write`=1 for exactly 1 cycle, `reg_write` never 1, 4 cycles total.
- beq (0x04) → `branch`=1, `alu_op`=01, `pc_src`=01 in cycle 3, then FETCH.
- Opcode 0x3F → `illegal_op`=1 and `instr_done`=1 in DECODE, then FETCH. Opcode 0x02 → JUMP with `pc_src`=10 with the macro defined; illegal without it.
- `reset` asserted during MEMWR → `mem_write`=0 that cycle, FETCH on the next edge, no `instr_done`.
